// File: rtl/conv_result_collector_pkg.sv
// Shared definitions for the convolution result collector and the conv engine:
// data width, default geometry and the collector FSM state encoding.
package conv_result_collector_pkg;

  localparam int DATA_W        = 32;
  localparam int M_DEFAULT     = 2;
  localparam int N_DUM_DEFAULT = 3;
  localparam int DEPTH_DEFAULT = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_COLLECT,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/conv_result_collector_buf.sv
// Result storage: one write port, asynchronous read, no reset on the array
// since every entry is written before it is read within a frame.
module result_buf #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/conv_result_collector.sv
// Collects one frame of convolution results in arrival order, then drains
// them downstream over a valid/ready handshake with a last marker.
module conv_result_collector
  import conv_result_collector_pkg::*;
#(
  parameter int M     = M_DEFAULT,
  parameter int N_DUM = N_DUM_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  stride,
  input  logic [2:0]  pad,
  input  logic [31:0] conv_out,
  input  logic        conv_done,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        cfg_err,
  output logic        overrun
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CMP_W = (PTR_W > 6) ? PTR_W : 6;

  state_e            state_q, state_d;
  logic [2:0]        stride_q, stride_d;
  logic [4:0]        rem_q, rem_d;
  logic [4:0]        quo_q, quo_d;
  logic [5:0]        total_q, total_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              cfg_err_q, cfg_err_d;
  logic              overrun_q, overrun_d;

  logic              buf_we;
  logic [DATA_W-1:0] buf_rdata;
  logic [5:0]        out_dim;
  logic              is_last_wr;
  logic              is_last_rd;

  result_buf #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_result_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_ptr_q),
    .wdata (conv_out),
    .raddr (rd_ptr_q),
    .rdata (buf_rdata)
  );

  assign out_dim    = {1'b0, quo_q} + 6'd1;
  assign is_last_wr = CMP_W'(wr_ptr_q) == (CMP_W'(total_q) - CMP_W'(1));
  assign is_last_rd = CMP_W'(rd_ptr_q) == (CMP_W'(total_q) - CMP_W'(1));

  assign out_valid = (state_q == ST_DRAIN);
  assign out_last  = out_valid && is_last_rd;
  assign out_data  = out_valid ? buf_rdata : '0;
  assign busy      = (state_q != ST_IDLE);
  assign cfg_err   = cfg_err_q;
  assign overrun   = overrun_q;

  // OUT_DIM is found by subtracting stride from (N_DUM+2*pad-M) once per
  // cycle; the quotient plus one is the output side.
  always_comb begin
    state_d   = state_q;
    stride_d  = stride_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    total_d   = total_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cfg_err_d = cfg_err_q;
    overrun_d = overrun_q;
    buf_we    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (stride == 3'd0 || pad > 3'd2) begin
            cfg_err_d = 1'b1;
          end else begin
            stride_d  = stride;
            rem_d     = 5'(N_DUM) + {1'b0, pad, 1'b0} - 5'(M);
            quo_d     = 5'd0;
            cfg_err_d = 1'b0;
            overrun_d = 1'b0;
            state_d   = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (rem_q >= {2'b00, stride_q}) begin
          rem_d = rem_q - {2'b00, stride_q};
          quo_d = quo_q + 5'd1;
        end else begin
          total_d = out_dim * out_dim;
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (conv_done) begin
          buf_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (is_last_wr) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          if (is_last_rd) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Applied after the start clear so a done coinciding with start still counts.
    if (conv_done && state_q != ST_COLLECT) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      stride_q  <= 3'd0;
      rem_q     <= 5'd0;
      quo_q     <= 5'd0;
      total_q   <= 6'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cfg_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stride_q  <= stride_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      total_q   <= total_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cfg_err_q <= cfg_err_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_conv_result_collector.sv
// Directed bench for conv_result_collector: frame geometry, ordering,
// backpressure, config errors, overrun and mid-frame reset.
module tb_conv_result_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  stride;
  logic [2:0]  pad;
  logic [31:0] conv_out;
  logic        conv_done;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        cfg_err;
  logic        overrun;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  conv_result_collector dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stride    (stride),
    .pad       (pad),
    .conv_out  (conv_out),
    .conv_done (conv_done),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .cfg_err   (cfg_err),
    .overrun   (overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Legal start, then enough idle cycles to cover the longest CALC phase.
  task automatic begin_frame(input logic [2:0] s, input logic [2:0] p);
    start  = 1'b1;
    stride = s;
    pad    = p;
    tick();
    start = 1'b0;
    repeat (8) tick();
  endtask

  task automatic push(input logic [31:0] d);
    conv_done = 1'b1;
    conv_out  = d;
    tick();
    conv_done = 1'b0;
    conv_out  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests_run += 6;
    if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (out_last !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_last: got %b expected 0", out_last); end
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    if (cfg_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_cfg_err: got %b expected 0", cfg_err); end
    if (overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
    if (out_data !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); end
    rst = 1'b0;
    tick();
  endtask

  // stride=1, pad=0 gives a 2x2 output: four results in arrival order.
  task automatic test_basic();
    logic [31:0] exp_data [4];
    exp_data = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    begin_frame(3'd1, 3'd0);
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_busy: got %b expected 1", busy); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_early_valid[%0d]: got %b expected 0", i, out_valid); end
      push(exp_data[i]);
    end
    tests_run++;
    if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_latency: got %b expected 1", out_valid); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests_run += 3;
      if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_valid[%0d]: got %b expected 1", i, out_valid); end
      if (out_data !== exp_data[i]) begin tests_failed++; $display("[TB] FAIL basic_data[%0d]: got %h expected %h", i, out_data, exp_data[i]); end
      if (out_last !== (i == 3)) begin tests_failed++; $display("[TB] FAIL basic_last[%0d]: got %b expected %b", i, out_last, (i == 3)); end
      tick();
    end
    out_ready = 1'b0;
    tests_run += 2;
    if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_extra_output: got %b expected 0", out_valid); end
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_idle: got %b expected 0", busy); end
  endtask

  // stride=1, pad=1 gives a 4x4 output: sixteen results.
  task automatic test_pad1();
    begin_frame(3'd1, 3'd1);
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL pad1_early_valid[%0d]: got %b expected 0", i, out_valid); end
      push(32'(i));
    end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tests_run += 3;
      if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL pad1_valid[%0d]: got %b expected 1", i, out_valid); end
      if (out_data !== 32'(i)) begin tests_failed++; $display("[TB] FAIL pad1_data[%0d]: got %h expected %h", i, out_data, 32'(i)); end
      if (out_last !== (i == 15)) begin tests_failed++; $display("[TB] FAIL pad1_last[%0d]: got %b expected %b", i, out_last, (i == 15)); end
      tick();
    end
    out_ready = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL pad1_busy_after: got %b expected 0", busy); end
  endtask

  // stride=2, pad=1 gives 2x2; ready pattern 1,0,0,1 stalls mid-drain.
  task automatic test_stall();
    logic [31:0] exp_data [4];
    logic        pat [4];
    int          idx;
    int          cyc;
    exp_data = '{32'hA0000001, 32'hB0000002, 32'hC0000003, 32'hD0000004};
    pat      = '{1'b1, 1'b0, 1'b0, 1'b1};
    begin_frame(3'd2, 3'd1);
    for (int i = 0; i < 4; i++) push(exp_data[i]);
    idx = 0;
    cyc = 0;
    while (idx < 4 && cyc < 40) begin
      out_ready = pat[cyc % 4];
      tests_run += 3;
      if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall_valid[%0d]: got %b expected 1", cyc, out_valid); end
      if (out_data !== exp_data[idx]) begin tests_failed++; $display("[TB] FAIL stall_data[%0d]: got %h expected %h", cyc, out_data, exp_data[idx]); end
      if (out_last !== (idx == 3)) begin tests_failed++; $display("[TB] FAIL stall_last[%0d]: got %b expected %b", cyc, out_last, (idx == 3)); end
      tick();
      if (out_ready) idx++;
      cyc++;
    end
    out_ready = 1'b0;
    tests_run += 2;
    if (idx !== 4) begin tests_failed++; $display("[TB] FAIL stall_count: got %0d expected 4", idx); end
    if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_extra_output: got %b expected 0", out_valid); end
  endtask

  task automatic test_cfg_err();
    start  = 1'b1;
    stride = 3'd0;
    pad    = 3'd0;
    tick();
    start = 1'b0;
    tests_run += 2;
    if (cfg_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL cfg_stride0_err: got %b expected 1", cfg_err); end
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL cfg_stride0_busy: got %b expected 0", busy); end
    start  = 1'b1;
    stride = 3'd1;
    pad    = 3'd3;
    tick();
    start = 1'b0;
    tests_run += 2;
    if (cfg_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL cfg_pad3_err: got %b expected 1", cfg_err); end
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL cfg_pad3_busy: got %b expected 0", busy); end
    start = 1'b1;
    pad   = 3'd0;
    tick();
    start = 1'b0;
    tests_run += 2;
    if (cfg_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL cfg_clear: got %b expected 0", cfg_err); end
    if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL cfg_legal_busy: got %b expected 1", busy); end
    repeat (8) tick();
    for (int i = 0; i < 4; i++) push(32'h11110000 + 32'(i));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests_run += 2;
      if (out_data !== 32'h11110000 + 32'(i)) begin tests_failed++; $display("[TB] FAIL cfg_data[%0d]: got %h expected %h", i, out_data, 32'h11110000 + 32'(i)); end
      if (out_last !== (i == 3)) begin tests_failed++; $display("[TB] FAIL cfg_last[%0d]: got %b expected %b", i, out_last, (i == 3)); end
      tick();
    end
    out_ready = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL cfg_done_idle: got %b expected 0", busy); end
  endtask

  // Extra engine strobes during DRAIN flag overrun without touching the buffer.
  task automatic test_overrun();
    begin_frame(3'd1, 3'd0);
    tests_run++;
    if (overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovr_initial: got %b expected 0", overrun); end
    for (int i = 0; i < 4; i++) push(32'h22220000 + 32'(i));
    push(32'hDEADBEEF);
    push(32'hCAFEF00D);
    tests_run += 2;
    if (overrun !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovr_flag: got %b expected 1", overrun); end
    if (out_data !== 32'h22220000) begin tests_failed++; $display("[TB] FAIL ovr_head: got %h expected 22220000", out_data); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests_run += 2;
      if (out_data !== 32'h22220000 + 32'(i)) begin tests_failed++; $display("[TB] FAIL ovr_data[%0d]: got %h expected %h", i, out_data, 32'h22220000 + 32'(i)); end
      if (out_last !== (i == 3)) begin tests_failed++; $display("[TB] FAIL ovr_last[%0d]: got %b expected %b", i, out_last, (i == 3)); end
      tick();
    end
    out_ready = 1'b0;
    tests_run += 2;
    if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovr_extra_output: got %b expected 0", out_valid); end
    if (overrun !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovr_sticky: got %b expected 1", overrun); end
  endtask

  task automatic test_reset_mid_frame();
    begin_frame(3'd1, 3'd0);
    push(32'h0BAD0001);
    push(32'h0BAD0002);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run += 3;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); end
    if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_valid: got %b expected 0", out_valid); end
    if (overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_overrun: got %b expected 0", overrun); end
    begin_frame(3'd1, 3'd0);
    for (int i = 0; i < 4; i++) push(32'h33330000 + 32'(i));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests_run += 3;
      if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstmid_valid[%0d]: got %b expected 1", i, out_valid); end
      if (out_data !== 32'h33330000 + 32'(i)) begin tests_failed++; $display("[TB] FAIL rstmid_data[%0d]: got %h expected %h", i, out_data, 32'h33330000 + 32'(i)); end
      if (out_last !== (i == 3)) begin tests_failed++; $display("[TB] FAIL rstmid_last[%0d]: got %b expected %b", i, out_last, (i == 3)); end
      tick();
    end
    repeat (2) begin
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_extra_output: got %b expected 0", out_valid); end
      tick();
    end
    out_ready = 1'b0;
  endtask

  // start with a coincident done in IDLE, then a start mid-collect that must be ignored.
  task automatic test_start_ignored();
    start     = 1'b1;
    stride    = 3'd1;
    pad       = 3'd0;
    conv_done = 1'b1;
    conv_out  = 32'hFFFFFFFF;
    tick();
    start     = 1'b0;
    conv_done = 1'b0;
    conv_out  = '0;
    tests_run += 2;
    if (overrun !== 1'b1) begin tests_failed++; $display("[TB] FAIL ign_start_done_ovr: got %b expected 1", overrun); end
    if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL ign_start_done_busy: got %b expected 1", busy); end
    repeat (8) tick();
    push(32'h44440000);
    start  = 1'b1;
    stride = 3'd1;
    pad    = 3'd1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 4; i++) push(32'h44440000 + 32'(i));
    tests_run++;
    if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL ign_total: got %b expected 1", out_valid); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests_run += 2;
      if (out_data !== 32'h44440000 + 32'(i)) begin tests_failed++; $display("[TB] FAIL ign_data[%0d]: got %h expected %h", i, out_data, 32'h44440000 + 32'(i)); end
      if (out_last !== (i == 3)) begin tests_failed++; $display("[TB] FAIL ign_last[%0d]: got %b expected %b", i, out_last, (i == 3)); end
      tick();
    end
    out_ready = 1'b0;
    tests_run += 2;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL ign_idle: got %b expected 0", busy); end
    if (overrun !== 1'b1) begin tests_failed++; $display("[TB] FAIL ign_overrun_sticky: got %b expected 1", overrun); end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    stride    = 3'd0;
    pad       = 3'd0;
    conv_out  = '0;
    conv_done = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_pad1();
    test_stall();
    test_cfg_err();
    test_overrun();
    test_reset_mid_frame();
    test_start_ignored();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
